// File: rtl/fsm_bit1_counter_pkg.sv
// ---------------------------------------------------------------------------
// fsm_bit1_counter_pkg : shared FSM encodings, width defaults and clog2 helper
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fsm_bit1_counter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  typedef logic [0:0] state_t;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_bit1_counter_bit_shift_acc.sv
// ---------------------------------------------------------------------------
// bit_shift_acc : shift register, bit index and ones accumulator for the
// population counter. Optional macro EARLY_DONE_EN adds early-finish detect.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bit_shift_acc
  import fsm_bit1_counter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              last_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  idx_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
      idx_d = '0;
    end else if (shift_i) begin
      sr_d  = sr_q >> 1;
      cnt_d = cnt_q + CNT_W'(sr_q[0]);
      idx_d = idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Early finish: nothing left above bit 0 means the current shift is the last useful one.
  always_comb begin
`ifdef EARLY_DONE_EN
    last_o = (idx_q == LAST_IDX) || (sr_q[DATA_W-1:1] == '0);
`else
    last_o = (idx_q == LAST_IDX);
`endif
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fsm_bit1_counter.sv
// ---------------------------------------------------------------------------
// fsm_bit1_counter : sequential popcount, one bit per clock, ready/load
// handshake. Optional macro EARLY_DONE_EN shortens latency for small words.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_bit1_counter
  import fsm_bit1_counter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = clog2(DATA_W + 1)
) (
  input  logic              iclk,
  input  logic              irstn,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic              o_ready
);

  state_t c_state;
  state_t n_state;
  logic   load_en;
  logic   shift_en;
  logic   last;

  always_comb begin
    n_state  = c_state;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (c_state)
      IDLE: begin
        if (i_load) begin
          load_en = 1'b1;
          n_state = COUNT;
        end
      end
      COUNT: begin
        shift_en = 1'b1;
        if (last) begin
          n_state = IDLE;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      c_state <= IDLE;
    end else begin
      c_state <= n_state;
    end
  end

  bit_shift_acc #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk_i   (iclk),
    .rst_ni  (irstn),
    .load_i  (load_en),
    .shift_i (shift_en),
    .data_i  (i_data),
    .cnt_o   (o_bit_cnt),
    .last_o  (last)
  );

  assign o_ready = (c_state == IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fsm_bit1_counter.sv
// ---------------------------------------------------------------------------
// tb_fsm_bit1_counter : scoreboard bench for fsm_bit1_counter (EARLY_DONE_EN aware)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fsm_bit1_counter;

  logic       iclk;
  logic       irstn;
  logic       i_load;
  logic [7:0] i_data;
  logic [3:0] o_bit_cnt;
  logic       o_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cnt;
    int         lat;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];

  fsm_bit1_counter #(.DATA_W(8), .CNT_W(4)) dut (
    .iclk      (iclk),
    .irstn     (irstn),
    .i_load    (i_load),
    .i_data    (i_data),
    .o_bit_cnt (o_bit_cnt),
    .o_ready   (o_ready)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  function automatic int pick_lat(input int full, input int early);
`ifdef EARLY_DONE_EN
    return early;
`else
    return full;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40; n++) begin
      @(negedge iclk);
      if (o_ready) return;
    end
    total++;
    bad++;
    $display("FAIL wait_ready: got timeout expected o_ready=1 within 40 cycles");
  endtask

  // Present one word at an IDLE cycle; the load is accepted on the next rising edge.
  task automatic issue(input logic [7:0] d, input logic [3:0] c, input int lat,
                       input bit chk_lat, input bit hold);
    exp_t e;
    wait_ready();
    i_data = d;
    i_load = 1'b1;
    e.cnt = c;
    e.lat = lat;
    e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge iclk);
    #1;
    if (!hold) i_load = 1'b0;
    i_data = ~d;
  endtask

  // Monitor: measure each busy window and score the result when o_ready returns.
  initial begin
    bit prev_ready;
    int low_cycles;
    exp_t e;
    prev_ready = 1'b1;
    low_cycles = 0;
    forever begin
      @(negedge iclk);
      if (!o_ready) begin
        low_cycles++;
      end else if (!prev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("bit_cnt", int'(o_bit_cnt), int'(e.cnt));
          if (e.chk_lat) check("latency", low_cycles, e.lat);
        end
        low_cycles = 0;
      end
      prev_ready = o_ready;
    end
  end

  initial begin
    irstn  = 1'b0;
    i_load = 1'b0;
    i_data = 8'h5F;
    repeat (3) @(negedge iclk);
    irstn = 1'b1;
    @(negedge iclk);
    check("reset_ready", int'(o_ready), 1);
    check("reset_cnt", int'(o_bit_cnt), 0);

    issue(8'h5F, 4'd6, pick_lat(8, 7), 1'b1, 1'b0);

    // Back-to-back with i_load held high; data scrambled during each count.
    issue(8'hEE, 4'd6, pick_lat(8, 8), 1'b1, 1'b1);
    issue(8'hF2, 4'd5, pick_lat(8, 8), 1'b1, 1'b1);
    issue(8'hCC, 4'd4, pick_lat(8, 8), 1'b1, 1'b0);

    issue(8'h00, 4'd0, pick_lat(8, 1), 1'b1, 1'b0);
    issue(8'hFF, 4'd8, pick_lat(8, 8), 1'b1, 1'b0);
    issue(8'h80, 4'd1, pick_lat(8, 8), 1'b1, 1'b0);
    issue(8'h0F, 4'd4, pick_lat(8, 4), 1'b1, 1'b0);

    // Load pulse in the middle of a count must not restart it.
    issue(8'hA5, 4'd4, pick_lat(8, 8), 1'b1, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    i_load = 1'b1;
    i_data = 8'hFF;
    @(posedge iclk);
    #1;
    i_load = 1'b0;

    // Reset during cycle 4 of counting 0xFF discards the partial count.
    issue(8'hFF, 4'd0, 0, 1'b0, 1'b0);
    repeat (3) @(posedge iclk);
    #2;
    irstn = 1'b0;
    #1;
    check("abort_ready", int'(o_ready), 1);
    check("abort_cnt", int'(o_bit_cnt), 0);
    repeat (2) @(negedge iclk);
    irstn = 1'b1;

    issue(8'h3C, 4'd4, pick_lat(8, 6), 1'b1, 1'b0);

    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge iclk);
    if (sb.size() != 0) check("drain", sb.size(), 0);
    repeat (2) @(negedge iclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
